mcs48_bus_if: RTL and testbench

MCS48_BUS_IF -- requirements
Module: mcs48_bus_if

---
 rtl/mcs48_bus_if.sv | 140 ++++++++++++++
 tb/tb_mcs48_bus_if.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs48_bus_if.sv
// MCS-48 core bus adapter: clock-enable divider, ALE address latch, ROM fetch FSM and XRAM access.
// Optional macro MCS48_BUS_WAIT_EN freezes the CPU clock-enable while a ROM fetch is outstanding.
module mcs48_bus_if #(
  parameter int CLK_DIV = 3,
  parameter int PA_W    = 12
) (
  input  logic            I_CLK,
  input  logic            I_RSTn,
  output logic            O_CLK_EN,
  input  logic            I_ALE,
  input  logic            I_PSENn,
  input  logic            I_RDn,
  input  logic            I_WRn,
  input  logic [7:0]      I_CPU_DB,
  output logic [7:0]      O_CPU_DB,
  input  logic [7:0]      I_P2,
  output logic [PA_W-1:0] O_ROM_A,
  output logic            O_ROM_REQ,
  input  logic            I_ROM_ACK,
  input  logic [7:0]      I_ROM_D,
  output logic [7:0]      O_XRAM_A,
  output logic [7:0]      O_XRAM_D,
  output logic            O_XRAM_WE,
  input  logic [7:0]      I_XRAM_D,
  output logic            O_ROM_LATE
);

  localparam int          CW   = 4;
  localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} rom_st_e;

  rom_st_e          st_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       addr_lo_q;
  logic [PA_W-9:0]  addr_hi_q;
  logic             psen_q, rd_q, wr_q;
  logic             psen_fall, rd_fall, wr_rise;
  logic [PA_W-1:0]  rom_a_q;
  logic [7:0]       rom_q, xd_q;
  logic             req_q, late_q, abort_q, we_q;
  logic             stall;
  logic             unused_ok;

`ifdef MCS48_BUS_WAIT_EN
  assign stall = (st_q == S_REQ);
`else
  assign stall = 1'b0;
`endif

  assign cnt_d    = stall ? cnt_q : ((cnt_q == CMAX) ? '0 : cnt_q + 1'b1);
  assign O_CLK_EN = (cnt_q == CMAX) && !stall;

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign psen_fall = psen_q & ~I_PSENn;
  assign rd_fall   = rd_q & ~I_RDn;
  assign wr_rise   = ~wr_q & I_WRn;

  // Address latch, strobe history and XRAM write path.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      addr_lo_q <= '0;
      addr_hi_q <= '0;
      psen_q    <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      xd_q      <= '0;
      we_q      <= 1'b0;
    end else begin
      if (I_ALE) begin
        addr_lo_q <= I_CPU_DB;
        addr_hi_q <= I_P2[PA_W-9:0];
      end
      psen_q <= I_PSENn;
      rd_q   <= I_RDn;
      wr_q   <= I_WRn;
      if (!I_WRn) xd_q <= I_CPU_DB;
      we_q <= wr_rise;
    end
  end

  // ROM fetch FSM; a fetch abandoned by PSEN rising still waits for the ack, then reports late.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      st_q    <= S_IDLE;
      rom_a_q <= '0;
      rom_q   <= '0;
      req_q   <= 1'b0;
      late_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      late_q <= 1'b0;
      case (st_q)
        S_IDLE: if (psen_fall) begin
          rom_a_q <= {addr_hi_q, addr_lo_q};
          req_q   <= 1'b1;
          abort_q <= 1'b0;
          st_q    <= S_REQ;
        end
        S_REQ: begin
          if (I_PSENn) abort_q <= 1'b1;
          if (I_ROM_ACK) begin
            req_q <= 1'b0;
            if (abort_q || I_PSENn) begin
              late_q <= 1'b1;
              st_q   <= S_IDLE;
            end else begin
              rom_q <= I_ROM_D;
              st_q  <= S_HOLD;
            end
          end
        end
        S_HOLD: if (I_PSENn) st_q <= S_IDLE;
        default: st_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    O_CPU_DB = 8'hFF;
    if (!I_RSTn)                          O_CPU_DB = 8'hFF;
    else if (st_q == S_HOLD && !I_PSENn)  O_CPU_DB = rom_q;
    else if (!I_RDn)                      O_CPU_DB = I_XRAM_D;
  end

  assign O_ROM_A    = rom_a_q;
  assign O_ROM_REQ  = req_q;
  assign O_ROM_LATE = late_q;
  assign O_XRAM_A   = addr_lo_q;
  assign O_XRAM_D   = xd_q;
  assign O_XRAM_WE  = we_q;

  // Upper port-2 bits and the read-strobe edge have no consumer in this adapter.
  assign unused_ok = ^{I_P2[7:PA_W-8], rd_fall};

endmodule

// File: tb/tb_mcs48_bus_if.sv
// Directed bench for mcs48_bus_if with a queue-based scoreboard of expected results.
module tb_mcs48_bus_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        ale, psen_n, rd_n, wr_n;
  logic [7:0]  cpu_db_i, cpu_db_o, p2;
  logic [11:0] rom_a;
  logic        rom_req, rom_ack, rom_late;
  logic [7:0]  rom_d;
  logic [7:0]  xram_a, xram_do, xram_di;
  logic        xram_we;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mcs48_bus_if #(.CLK_DIV(3), .PA_W(12)) dut (
    .I_CLK(clk), .I_RSTn(rst_n), .O_CLK_EN(clk_en),
    .I_ALE(ale), .I_PSENn(psen_n), .I_RDn(rd_n), .I_WRn(wr_n),
    .I_CPU_DB(cpu_db_i), .O_CPU_DB(cpu_db_o), .I_P2(p2),
    .O_ROM_A(rom_a), .O_ROM_REQ(rom_req), .I_ROM_ACK(rom_ack), .I_ROM_D(rom_d),
    .O_XRAM_A(xram_a), .O_XRAM_D(xram_do), .O_XRAM_WE(xram_we), .I_XRAM_D(xram_di),
    .O_ROM_LATE(rom_late)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [15:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errs++;
      $error("FAIL scoreboard_empty: got %0h expected none", obs);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, obs, e.v);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!rom_req && n < 8) begin
      tick(); settle();
      n++;
    end
    chk(tag, 16'(rom_req), 16'd1);
  endtask

  task automatic clk_en_seq(input string tag);
    for (int k = 0; k < 6; k++) push(tag, (k % 3 == 2) ? 16'd1 : 16'd0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      settle();
      pop_chk(16'(clk_en));
    end
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0; ale = 1'b0; psen_n = 1'b1; rd_n = 1'b0; wr_n = 1'b1;
    cpu_db_i = '0; p2 = '0; rom_ack = 1'b0; rom_d = '0; xram_di = 8'h55;
    tick(); tick(); settle();
    chk("rst_clk_en",   16'(clk_en),   16'd0);
    chk("rst_rom_req",  16'(rom_req),  16'd0);
    chk("rst_rom_late", 16'(rom_late), 16'd0);
    chk("rst_xram_we",  16'(xram_we),  16'd0);
    chk("rst_rom_a",    16'(rom_a),    16'h000);
    chk("rst_xram_a",   16'(xram_a),   16'h00);
    chk("rst_xram_d",   16'(xram_do),  16'h00);
    chk("rst_cpu_db",   16'(cpu_db_o), 16'hFF);
    rd_n = 1'b1;
    tick();
    rst_n = 1'b1;
    clk_en_seq("clk_en_after_rst");

    // ROM fetch, high P2 bits must not leak into the address
    tick();
    ale = 1'b1; cpu_db_i = 8'h5A; p2 = 8'hF3;
    tick();
    ale = 1'b0; cpu_db_i = 8'h00; psen_n = 1'b0;
    push("fetch_rom_a", 16'h35A);
    wait_req("fetch_req");
    pop_chk(16'(rom_a));
    rom_ack = 1'b1; rom_d = 8'hC3;
    tick();
    rom_ack = 1'b0; rom_d = 8'h00; settle();
    chk("fetch_req_drop", 16'(rom_req),  16'd0);
    chk("fetch_db",       16'(cpu_db_o), 16'hC3);
    tick(); settle();
    chk("fetch_db_hold",  16'(cpu_db_o), 16'hC3);
    chk("fetch_a_hold",   16'(rom_a),    16'h35A);
    psen_n = 1'b1; settle();
    chk("fetch_db_end",   16'(cpu_db_o), 16'hFF);
    tick();

    // ack in IDLE has no effect
    rom_ack = 1'b1; rom_d = 8'h44;
    tick(); tick();
    rom_ack = 1'b0; settle();
    chk("idle_ack_req",  16'(rom_req),  16'd0);
    chk("idle_ack_late", 16'(rom_late), 16'd0);

    // PSEN rises before ack, ALE during REQ must not move the ROM address
    ale = 1'b1; cpu_db_i = 8'h12; p2 = 8'hF1;
    tick();
    ale = 1'b0; psen_n = 1'b0;
    push("late_rom_a", 16'h112);
    wait_req("late_req");
    pop_chk(16'(rom_a));
    psen_n = 1'b1; ale = 1'b1; cpu_db_i = 8'hAB;
    tick();
    ale = 1'b0; settle();
    chk("late_req_held", 16'(rom_req), 16'd1);
    chk("late_a_frozen", 16'(rom_a),   16'h112);
    rom_ack = 1'b1; rom_d = 8'hEE;
    tick();
    rom_ack = 1'b0; settle();
    chk("late_pulse",    16'(rom_late), 16'd1);
    chk("late_req_drop", 16'(rom_req),  16'd0);
    chk("late_db",       16'(cpu_db_o), 16'hFF);
    tick(); settle();
    chk("late_one_cyc",  16'(rom_late), 16'd0);
    psen_n = 1'b0; settle();
    chk("late_idle_db",  16'(cpu_db_o), 16'hFF);

    // PSEN beats RD while holding ROM data
    push("prio_rom_a", 16'h1AB);
    wait_req("prio_req");
    pop_chk(16'(rom_a));
    rom_ack = 1'b1; rom_d = 8'h99;
    tick();
    rom_ack = 1'b0; rd_n = 1'b0; xram_di = 8'h11; settle();
    chk("psen_prio", 16'(cpu_db_o), 16'h99);
    psen_n = 1'b1; settle();
    chk("rd_path",   16'(cpu_db_o), 16'h11);
    tick();
    rd_n = 1'b1; settle();
    chk("bus_float", 16'(cpu_db_o), 16'hFF);

    // XRAM write: single WE pulse the cycle after WRn rises
    ale = 1'b1; cpu_db_i = 8'h20;
    tick();
    ale = 1'b0; settle();
    chk("xram_a", 16'(xram_a), 16'h20);
    wr_n = 1'b0; cpu_db_i = 8'h77;
    tick(); settle();
    chk("xram_d_load", 16'(xram_do), 16'h77);
    chk("xram_we_low", 16'(xram_we), 16'd0);
    wr_n = 1'b1; cpu_db_i = 8'h00;
    tick(); settle();
    chk("xram_we_pulse", 16'(xram_we), 16'd1);
    chk("xram_we_a",     16'(xram_a),  16'h20);
    chk("xram_we_d",     16'(xram_do), 16'h77);
    push("xram_we_extra", 16'd0);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); settle();
      if (xram_we) pulses++;
    end
    pop_chk(16'(pulses));

    // WR rising edge together with PSEN falling edge
    wr_n = 1'b0; cpu_db_i = 8'h3C;
    tick();
    wr_n = 1'b1; psen_n = 1'b0;
    push("coinc_rom_a", 16'h120);
    tick(); settle();
    chk("coinc_we",  16'(xram_we), 16'd1);
    chk("coinc_req", 16'(rom_req), 16'd1);
    pop_chk(16'(rom_a));
    chk("coinc_xd",  16'(xram_do), 16'h3C);
    rom_ack = 1'b1;
    tick();
    rom_ack = 1'b0; psen_n = 1'b1;
    tick();

`ifdef MCS48_BUS_WAIT_EN
    // stalled fetch: no enable pulses while waiting, period restored after ack
    psen_n = 1'b0;
    wait_req("stall_req");
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick(); settle();
      if (clk_en) pulses++;
    end
    chk("stall_no_en", 16'(pulses), 16'd0);
    rom_ack = 1'b1;
    tick();
    rom_ack = 1'b0; psen_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      settle();
      if (clk_en) pulses++;
      tick();
    end
    chk("stall_resume", 16'(pulses), 16'd2);
`endif

    // reset mid-REQ drops the request; a later ack is ignored
    psen_n = 1'b0;
    wait_req("rstreq_req");
    rst_n = 1'b0; psen_n = 1'b1; settle();
    chk("rstreq_drop", 16'(rom_req), 16'd0);
    tick();
    rst_n = 1'b1; rom_ack = 1'b1; rom_d = 8'h05;
    clk_en_seq("clk_en_rerelease");
    rom_ack = 1'b0; settle();
    chk("rstreq_ack_ign", 16'(rom_req),  16'd0);
    chk("rstreq_no_late", 16'(rom_late), 16'd0);
    chk("rstreq_db",      16'(cpu_db_o), 16'hFF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
